mitchell_seq_multiplier: RTL and testbench

Sequenced Mitchell logarithmic approximate multiplier. It time-shares a single `mitchell_pre_approximate` instance (leading-one detector, priority encoder and mantissa shifter) between both operands. An FSM steers operand A, then operand B, through the shared log-conversion stage, then performs the antilog combine. It sits at the PE/MAC boundary as an area-reduced alternative to a fully parallel two-converter Mitchell multiplier, with a valid/ready handshake on both sides.

---
 rtl/mitchell_seq_multiplier_if.sv | 30 +++
 rtl/mitchell_seq_multiplier.sv | 195 +++++++++++++++++++
 tb/tb_mitchell_seq_multiplier.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mitchell_seq_multiplier_if.sv
// -----------------------------------------------------------------------------
// mitchell_seq_multiplier_if
// Handshake bundle for the sequenced Mitchell multiplier.
//   in_valid / in_ready / a / b      : operand side (master drives valid+data)
//   out_valid / out_ready / product  : result side (master drives ready)
//   busy                             : block is working on an operation
// Modports: master (producer/consumer of the block), slave (the multiplier).
// -----------------------------------------------------------------------------
interface mitchell_seq_multiplier_if #(
    parameter int DW = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     a;
    logic [DW-1:0]     b;
    logic              out_valid;
    logic              out_ready;
    logic [2*DW-1:0]   product;
    logic              busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/mitchell_seq_multiplier.sv
// -----------------------------------------------------------------------------
// mitchell_seq_multiplier
// Sequenced Mitchell logarithmic approximate multiplier. One shared
// log-conversion stage (mitchell_pre_approximate) converts operand A, then
// operand B; the antilog combine then forms the approximate product.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mitchell_seq_multiplier_if.slave (valid/ready in, valid/ready out,
//          product, busy)
// Optional feature macro: MITCHELL_ZERO_BYPASS_EN -- a zero operand skips the
// conversion/antilog states and the FSM goes straight to DONE with product 0.
// -----------------------------------------------------------------------------

// Leading-one detector, priority encoder and mantissa shifter.
//   a         : unsigned operand
//   k         : position of the leading one
//   x         : bits below the leading one, MSB-aligned (fraction)
//   zero_flag : operand is zero
module mitchell_pre_approximate #(
    parameter int A_BW = 8,
    parameter int K_BW = $clog2(A_BW)
) (
    input  logic [A_BW-1:0] a,
    output logic [K_BW-1:0] k,
    output logic [A_BW-1:0] x,
    output logic            zero_flag
);
    logic [2*A_BW-1:0] shifted_s;
    logic [K_BW:0]     sh_amt_s;

    // Priority encode the leading one and left-align the remaining fraction.
    always_comb begin
        k         = '0;
        zero_flag = (a == '0);
        for (int i = 0; i < A_BW; i++) begin
            if (a[i]) begin
                k = i[K_BW-1:0];
            end else begin
                k = k;
            end
        end
        // Shifting by A_BW-k pushes the leading one just past bit A_BW-1.
        sh_amt_s  = (K_BW+1)'(A_BW) - {1'b0, k};
        shifted_s = {{A_BW{1'b0}}, a} << sh_amt_s;
        x         = shifted_s[A_BW-1:0];
    end
endmodule

module mitchell_seq_multiplier #(
    parameter int DW = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    mitchell_seq_multiplier_if.slave   bus
);
    localparam int KW = $clog2(DW);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOG_A   = 3'd1,
        LOG_B   = 3'd2,
        ANTILOG = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state;
    logic [DW-1:0]     a_reg, b_reg;
    logic [KW-1:0]     k_a, k_b;
    logic [DW-1:0]     x_a, x_b;
    logic              z_a, z_b;
    logic [2*DW-1:0]   product_reg;
    logic              in_ready_reg, out_valid_reg, busy_reg;

    logic [DW-1:0]     conv_in;
    logic [KW-1:0]     conv_k;
    logic [DW-1:0]     conv_x;
    logic              conv_z;

    logic [DW:0]       s;
    logic [DW:0]       m;
    logic [KW:0]       e_base, e;
    logic [3*DW-1:0]   prod_wide;
    logic [2*DW-1:0]   antilog_val;

    assign conv_in = (state == LOG_A) ? a_reg : b_reg;

    mitchell_pre_approximate #(.A_BW(DW)) u_pre (
        .a         (conv_in),
        .k         (conv_k),
        .x         (conv_x),
        .zero_flag (conv_z)
    );

    // Antilog combine: add fractions, renormalise on carry, shift by exponent.
    always_comb begin
        s      = {1'b0, x_a} + {1'b0, x_b};
        e_base = {1'b0, k_a} + {1'b0, k_b};
        if (s[DW]) begin
            m = s;
            e = e_base + {{KW{1'b0}}, 1'b1};
        end else begin
            m = {1'b1, s[DW-1:0]};
            e = e_base;
        end
        prod_wide = {{(2*DW-1){1'b0}}, m} << e;
        if (z_a || z_b) begin
            antilog_val = '0;
        end else begin
            antilog_val = prod_wide[3*DW-1:DW];
        end
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            k_a           <= '0;
            x_a           <= '0;
            z_a           <= 1'b0;
            k_b           <= '0;
            x_b           <= '0;
            z_b           <= 1'b0;
            product_reg   <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_reg) begin
                        a_reg        <= bus.a;
                        b_reg        <= bus.b;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
`ifdef MITCHELL_ZERO_BYPASS_EN
                        if ((bus.a == '0) || (bus.b == '0)) begin
                            product_reg   <= '0;
                            out_valid_reg <= 1'b1;
                            state         <= DONE;
                        end else begin
                            state <= LOG_A;
                        end
`else
                        state <= LOG_A;
`endif
                    end else begin
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                    end
                end
                LOG_A: begin
                    k_a   <= conv_k;
                    x_a   <= conv_x;
                    z_a   <= conv_z;
                    state <= LOG_B;
                end
                LOG_B: begin
                    k_b   <= conv_k;
                    x_b   <= conv_x;
                    z_b   <= conv_z;
                    state <= ANTILOG;
                end
                ANTILOG: begin
                    product_reg   <= antilog_val;
                    out_valid_reg <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        state <= DONE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.product   = product_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_mitchell_seq_multiplier.sv
module tb_mitchell_seq_multiplier;
    localparam int DW = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   exp_q[$];

    mitchell_seq_multiplier_if #(.DW(DW)) bus ();

    mitchell_seq_multiplier #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MITCHELL_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 4;
`endif

    // Reference Mitchell approximation using integer arithmetic.
    function automatic int model(input int av, input int bv);
        int ka, kb, xa, xb, s;
        if (av == 0 || bv == 0) return 0;
        ka = 0;
        kb = 0;
        for (int i = 0; i < DW; i++) begin
            if ((av >> i) != 0) ka = i;
            if ((bv >> i) != 0) kb = i;
        end
        xa = ((av - (1 << ka)) * (1 << DW)) >> ka;
        xb = ((bv - (1 << kb)) * (1 << DW)) >> kb;
        s  = xa + xb;
        if (s >= (1 << DW)) return (s << (ka + kb + 1)) >> DW;
        return (((1 << DW) + s) << (ka + kb)) >> DW;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Wait for in_ready, present one operand pair, record its expectation.
    task automatic send(input int av, input int bv, input int exp_p);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", 32'(n < 20), 32'd1);
        bus.a        = 8'(av);
        bus.b        = 8'(bv);
        bus.in_valid = 1'b1;
        exp_q.push_back(exp_p);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Wait for out_valid, check latency and product, then consume it.
    task automatic receive(input string tag, input int exp_lat);
        int lat;
        int exp_p;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
        if (exp_q.size() > 0) begin
            exp_p = exp_q.pop_front();
            chk({tag, "_product"}, 32'(bus.product), 32'(exp_p));
        end else begin
            chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        chk({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int held;
        int hits;
        int ra, rb;
        checks       = 0;
        failures     = 0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.out_ready = 1'b1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready_held", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_product", 32'(bus.product), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);

        send(8, 8, 64);      chk("busy_running", 32'(bus.busy), 32'd1);
        receive("8x8", 4);
        send(12, 10, 112);   receive("12x10", 4);
        send(12, 14, 160);   receive("12x14", 4);
        send(255, 255, 65024); receive("255x255", 4);
        send(1, 1, 1);       receive("1x1", 4);
        send(1, 200, 200);   receive("1x200", 4);
        send(0, 77, 0);      receive("0x77", ZERO_LAT);
        send(3, 5, 14);      receive("3x5", 4);
        send(200, 0, 0);     receive("200x0", ZERO_LAT);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom_range(1, 255);
            rb = $urandom_range(1, 255);
            send(ra, rb, model(ra, rb));
            receive("random", 4);
        end

        // Backpressure: DONE must hold with stable product, ignoring in_valid.
        bus.out_ready = 1'b0;
        send(12, 14, 160);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_out_valid_rise", 32'(bus.out_valid), 32'd1);
        held = int'(bus.product);
        for (int i = 0; i < 10; i++) begin
            bus.a        = 8'd99;
            bus.b        = 8'd99;
            bus.in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            chk("bp_out_valid_hold", 32'(bus.out_valid), 32'd1);
            chk("bp_product_hold", 32'(bus.product), 32'(held));
            chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        receive("bp_release", 1);
        chk("bp_back_idle", 32'(bus.in_ready), 32'd1);
        send(8, 8, 64);      receive("after_bp", 4);

        // Reset in LOG_B drops the operation without an out_valid pulse.
        send(200, 3, model(200, 3));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_product", 32'(bus.product), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) hits++;
        end
        chk("midrst_no_out_valid", 32'(hits), 32'd0);
        send(6, 6, 32);      receive("6x6_after_rst", 4);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
